// File: rtl/pdp_operand_fetch.sv
// pdp_operand_fetch
// Resolves one PDP-11 instruction operand. It takes the 3-bit addressing mode
// and register field, computes the effective address, applies the register
// side effects (autoincrement, autodecrement, PC advance) and fetches the
// operand over a single-outstanding memory read port.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   start                 begin resolution (sampled only while idle)
//   mode, rsel, byte_op   addressing mode, register field, byte/word select
//   busy, done, err       status: busy after accept, done pulse, odd-address error
//   operand, ea, ea_valid result, held until the next accepted start
//   rf_rd_idx/rf_rd_data  register-file read (combinational data)
//   rf_wr_en/idx/data     register-file write strobe (one pulse per side effect)
//   mem_req/addr/ack/rdata memory read port
//
// Memory handshake: mem_req and mem_addr stay stable until a cycle in which
// mem_ack is high while mem_req is high; that cycle carries mem_rdata and the
// sequencer advances on the following clock edge. mem_ack seen while mem_req
// is low has no effect. mem_addr is always word aligned.
module pdp_operand_fetch #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_LEN  = 16,
  parameter int SP_IDX    = 6,
  parameter int PC_IDX    = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [2:0]           rsel,
  input  logic                 byte_op,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WORD_SIZE-1:0] operand,
  output logic [ADDR_LEN-1:0]  ea,
  output logic                 ea_valid,
  output logic [2:0]           rf_rd_idx,
  input  logic [WORD_SIZE-1:0] rf_rd_data,
  output logic                 rf_wr_en,
  output logic [2:0]           rf_wr_idx,
  output logic [WORD_SIZE-1:0] rf_wr_data,
  output logic                 mem_req,
  output logic [ADDR_LEN-1:0]  mem_addr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int HWORD = WORD_SIZE / 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IDX  = 3'd1;
  localparam logic [2:0] S_PTR  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] SP_SEL = 3'(SP_IDX);
  localparam logic [2:0] PC_SEL = 3'(PC_IDX);
  localparam logic [ADDR_LEN-1:0] TWO = ADDR_LEN'(2);

  logic [2:0]           state;
  logic [2:0]           mode_q;
  logic [2:0]           rsel_q;
  logic                 byte_q;
  logic [ADDR_LEN-1:0]  fetch_addr;
  logic [ADDR_LEN-1:0]  ea_q;
  logic                 ea_valid_q;
  logic [WORD_SIZE-1:0] operand_q;
  logic                 err_q;

  logic                 accept;
  logic [ADDR_LEN-1:0]  rn_addr;
  logic [ADDR_LEN-1:0]  step;
  logic [ADDR_LEN-1:0]  inc_addr;
  logic [ADDR_LEN-1:0]  dec_addr;
  logic [ADDR_LEN-1:0]  rdata_addr;
  logic [ADDR_LEN-1:0]  index_sum;
  logic [WORD_SIZE-1:0] byte_val;
  logic                 in_fetch;
  logic                 odd_fault;
  logic                 acked;

  // The accept cycle is the IDLE cycle with start high; reset_n gates it so
  // nothing is written to the register file while reset is asserted.
  assign accept = reset_n && start && (state == S_IDLE);

  assign rn_addr    = ADDR_LEN'(rf_rd_data);
  assign rdata_addr = ADDR_LEN'(mem_rdata);

  // Byte ops on SP/PC and deferred modes still move by a full word.
  assign step = (!byte_op || rsel == SP_SEL || rsel == PC_SEL ||
                 mode == 3'd3 || mode == 3'd5) ? TWO : ADDR_LEN'(1);
  assign inc_addr = rn_addr + step;
  assign dec_addr = rn_addr - step;

  // In IDX_FETCH the read port addresses Rn again, so rsel=PC already sees
  // the PC advanced by the accept-cycle write.
  assign index_sum = rdata_addr + rn_addr;

  assign byte_val = fetch_addr[0] ? WORD_SIZE'(mem_rdata[WORD_SIZE-1:HWORD])
                                  : WORD_SIZE'(mem_rdata[HWORD-1:0]);

  assign in_fetch  = (state == S_IDX) || (state == S_PTR) || (state == S_DATA);
  // Only byte data accesses may target an odd address.
  assign odd_fault = fetch_addr[0] && !((state == S_DATA) && byte_q);
  assign mem_req   = in_fetch && !odd_fault;
  assign mem_addr  = mem_req ? {fetch_addr[ADDR_LEN-1:1], 1'b0} : '0;
  assign acked     = mem_req && mem_ack;

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_DONE) && err_q;
  assign operand  = operand_q;
  assign ea       = ea_q;
  assign ea_valid = ea_valid_q;

  // Index modes read the PC in the accept cycle; all others read Rn.
  always_comb begin
    rf_rd_idx = 3'd0;
    if (accept) begin
      rf_rd_idx = (mode[2:1] == 2'b11) ? PC_SEL : rsel;
    end else if (state == S_IDX) begin
      rf_rd_idx = rsel_q;
    end
  end

  // All register side effects are issued in the accept cycle.
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_idx  = 3'd0;
    rf_wr_data = '0;
    if (accept) begin
      case (mode)
        3'd2, 3'd3: begin
          rf_wr_en   = 1'b1;
          rf_wr_idx  = rsel;
          rf_wr_data = WORD_SIZE'(inc_addr);
        end
        3'd4, 3'd5: begin
          rf_wr_en   = 1'b1;
          rf_wr_idx  = rsel;
          rf_wr_data = WORD_SIZE'(dec_addr);
        end
        3'd6, 3'd7: begin
          rf_wr_en   = 1'b1;
          rf_wr_idx  = PC_SEL;
          rf_wr_data = WORD_SIZE'(rn_addr + TWO);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      mode_q     <= 3'd0;
      rsel_q     <= 3'd0;
      byte_q     <= 1'b0;
      fetch_addr <= '0;
      ea_q       <= '0;
      ea_valid_q <= 1'b0;
      operand_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            rsel_q     <= rsel;
            byte_q     <= byte_op;
            err_q      <= 1'b0;
            operand_q  <= '0;
            ea_q       <= '0;
            ea_valid_q <= (mode != 3'd0);
            case (mode)
              3'd0: begin
                operand_q <= byte_op ? WORD_SIZE'(rf_rd_data[HWORD-1:0]) : rf_rd_data;
                state     <= S_DONE;
              end
              3'd1, 3'd2: begin
                fetch_addr <= rn_addr;
                ea_q       <= rn_addr;
                state      <= S_DATA;
              end
              3'd3: begin
                fetch_addr <= rn_addr;
                state      <= S_PTR;
              end
              3'd4: begin
                fetch_addr <= dec_addr;
                ea_q       <= dec_addr;
                state      <= S_DATA;
              end
              3'd5: begin
                fetch_addr <= dec_addr;
                state      <= S_PTR;
              end
              default: begin
                fetch_addr <= rn_addr;  // index word lives at the old PC
                state      <= S_IDX;
              end
            endcase
          end
        end
        S_IDX: begin
          if (odd_fault) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (acked) begin
            fetch_addr <= index_sum;
            if (mode_q == 3'd6) begin
              ea_q  <= index_sum;
              state <= S_DATA;
            end else begin
              state <= S_PTR;
            end
          end
        end
        S_PTR: begin
          if (odd_fault) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (acked) begin
            fetch_addr <= rdata_addr;
            ea_q       <= rdata_addr;
            state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (odd_fault) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (acked) begin
            operand_q <= byte_q ? byte_val : mem_rdata;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp_operand_fetch.sv
// Bench for pdp_operand_fetch: directed cases plus randomized operands,
// checked by a scoreboard fed from a high-level operand-resolution model.
module tb_pdp_operand_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [2:0]  rsel = 3'd0;
  logic        byte_op = 1'b0;
  logic        busy, done, err, ea_valid, rf_wr_en, mem_req;
  logic [15:0] operand, ea, rf_wr_data, mem_addr, rf_rd_data;
  logic [2:0]  rf_rd_idx, rf_wr_idx;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;

  pdp_operand_fetch dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .rsel(rsel),
    .byte_op(byte_op), .busy(busy), .done(done), .err(err), .operand(operand),
    .ea(ea), .ea_valid(ea_valid), .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // ---------------- register file and memory ----------------
  logic [15:0] rf [8];
  logic [15:0] rf_next [8];
  logic        load_req = 1'b0;
  logic [15:0] mem [32768];

  assign rf_rd_data = rf[rf_rd_idx];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_next[i];
    end else if (rf_wr_en) begin
      rf[rf_wr_idx] <= rf_wr_data;
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [15:0]  operand;
    logic [15:0]  ea;
    logic         ea_valid;
    logic         err;
    logic [127:0] regs;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int tests_run = 0;
  int tests_failed = 0;

  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          req_total = 0;
  logic [15:0] last_req_addr = 16'h0;
  logic [15:0] req_rise_addr = 16'h0;
  logic        done_err = 1'b0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_rstn = 1'b0;
  logic [15:0] prev_addr = 16'h0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pack_rf();
    return {rf[7], rf[6], rf[5], rf[4], rf[3], rf[2], rf[1], rf[0]};
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem[a[15:1]];
  endfunction

  // Reference: resolve the operand straight from the addressing-mode rules.
  function automatic exp_t model(input logic [2:0] m, input logic [2:0] r, input logic b);
    logic [15:0] g [8];
    logic [15:0] step, a, p, x, w, pc_old;
    logic        want_data, want_ptr;
    exp_t e;
    for (int i = 0; i < 8; i++) g[i] = rf[i];
    e = '0;
    e.ea_valid = (m != 3'd0);
    step = (!b || r == 3'd6 || r == 3'd7 || m == 3'd3 || m == 3'd5) ? 16'd2 : 16'd1;
    want_data = 1'b1;
    want_ptr = 1'b0;
    a = 16'h0;
    p = 16'h0;
    case (m)
      3'd0: begin
        e.operand = b ? {8'h00, g[r][7:0]} : g[r];
        want_data = 1'b0;
      end
      3'd1: a = g[r];
      3'd2: begin a = g[r]; g[r] = g[r] + step; end
      3'd3: begin p = g[r]; g[r] = g[r] + 16'd2; want_ptr = 1'b1; end
      3'd4: begin g[r] = g[r] - step; a = g[r]; end
      3'd5: begin g[r] = g[r] - 16'd2; p = g[r]; want_ptr = 1'b1; end
      default: begin
        pc_old = g[7];
        g[7] = g[7] + 16'd2;
        if (pc_old[0]) begin
          e.err = 1'b1;
          want_data = 1'b0;
        end else begin
          x = mem_rd(pc_old);
          if (m == 3'd6) a = x + g[r];
          else begin p = x + g[r]; want_ptr = 1'b1; end
        end
      end
    endcase
    if (want_ptr) begin
      if (p[0]) begin e.err = 1'b1; want_data = 1'b0; end
      else a = mem_rd(p);
    end
    if (want_data) begin
      e.ea = a;
      if (!b && a[0]) e.err = 1'b1;
      else begin
        w = mem_rd(a);
        e.operand = b ? (a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]}) : w;
      end
    end
    e.regs = {g[7], g[6], g[5], g[4], g[3], g[2], g[1], g[0]};
    return e;
  endfunction

  // ---------------- monitor + memory responder ----------------
  always @(negedge clk) begin
    if (mem_req) check("mem_addr_aligned", 128'(mem_addr[0]), 128'd0);
    if (prev_req && !prev_ack && prev_rstn) begin
      check("mem_req_held", 128'(mem_req), 128'd1);
      check("mem_addr_held", 128'(mem_addr), 128'(prev_addr));
    end
    if (err) check("err_with_done", 128'(done), 128'd1);
    if (done) begin
      done_err = err;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 128'(done), 128'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("operand", 128'(operand), 128'(mon_e.operand));
        check("ea", 128'(ea), 128'(mon_e.ea));
        check("ea_valid", 128'(ea_valid), 128'(mon_e.ea_valid));
        check("err", 128'(err), 128'(mon_e.err));
        check("regfile", pack_rf(), mon_e.regs);
      end
    end
    if (mem_req) begin
      req_total++;
      last_req_addr = mem_addr;
      if (!prev_req) req_rise_addr = mem_addr;
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr[15:1]];
        wait_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      mem_ack = ($urandom_range(0, 3) == 0);  // stray acks must be ignored
      mem_rdata = 16'($urandom);
    end
    prev_req = mem_req;
    prev_ack = mem_ack;
    prev_addr = mem_addr;
    prev_rstn = reset_n;
  end

  // ---------------- driver tasks ----------------
  task automatic load_regs();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] m, input logic [2:0] r, input logic b,
                        input int dly, output int lat, output int reqc);
    int r0;
    ack_delay = dly;
    exp_q.push_back(model(m, r, b));
    r0 = req_total;
    start = 1'b1; mode = m; rsel = r; byte_op = b;
    @(posedge clk); #1;
    start = 1'b0; mode = 3'($urandom); rsel = 3'($urandom); byte_op = 1'($urandom);
    lat = 1;
    while (!done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", 128'(done), 128'd1);
    reqc = req_total - r0;
    start = 1'b1; mode = 3'd0;  // start during DONE must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_after_done", 128'({busy, done}), 128'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 128'({busy, done, err, operand, ea, ea_valid, rf_rd_idx, rf_wr_en,
                      rf_wr_idx, rf_wr_data, mem_req, mem_addr}), 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, reqc;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) rf_next[i] = 16'h0;
    load_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    load_req = 1'b0;
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // register mode, byte
    rf_next[3] = 16'h1234;
    load_regs();
    run_op(3'd0, 3'd3, 1'b1, 0, lat, reqc);
    check("mode0_latency", 128'(lat), 128'd1);
    check("mode0_no_req", 128'(reqc), 128'd0);
    check("mode0_operand", 128'(operand), 128'h0034);
    check("mode0_ea_valid", 128'(ea_valid), 128'd0);

    // autoincrement byte at odd address
    rf_next[2] = 16'h0101;
    mem[16'h0100 >> 1] = 16'hAB12;
    load_regs();
    run_op(3'd2, 3'd2, 1'b1, 0, lat, reqc);
    check("m2_reg", 128'(rf[2]), 128'h0102);
    check("m2_mem_addr", 128'(last_req_addr), 128'h0100);
    check("m2_operand", 128'(operand), 128'h00AB);
    check("m2_ea", 128'(ea), 128'h0101);

    // autodecrement byte on SP with slow memory
    rf_next[6] = 16'h0200;
    load_regs();
    run_op(3'd4, 3'd6, 1'b1, 3, lat, reqc);
    check("m4_sp", 128'(rf[6]), 128'h01FE);
    check("m4_ea", 128'(ea), 128'h01FE);
    check("m4_req_cycles", 128'(reqc), 128'd4);

    // index on PC
    rf_next[7] = 16'h1000;
    mem[16'h1000 >> 1] = 16'h0010;
    mem[16'h1012 >> 1] = 16'h5555;
    load_regs();
    run_op(3'd6, 3'd7, 1'b0, 0, lat, reqc);
    check("m6_pc", 128'(rf[7]), 128'h1002);
    check("m6_ea", 128'(ea), 128'h1012);
    check("m6_operand", 128'(operand), 128'h5555);

    // odd word access
    rf_next[1] = 16'h0301;
    load_regs();
    run_op(3'd1, 3'd1, 1'b0, 0, lat, reqc);
    check("odd_err", 128'(done_err), 128'd1);
    check("odd_no_req", 128'(reqc), 128'd0);
    check("odd_operand", 128'(operand), 128'd0);

    // autodecrement deferred wrapping below zero
    rf_next[0] = 16'h0000;
    mem[16'hFFFE >> 1] = 16'h0400;
    load_regs();
    run_op(3'd5, 3'd0, 1'b0, 0, lat, reqc);
    check("m5_wrap_reg", 128'(rf[0]), 128'hFFFE);
    check("m5_ptr_addr", 128'(req_rise_addr), 128'hFFFE);

    // reset during the pointer fetch of an index-deferred operand
    rf_next[7] = 16'h2000;
    rf_next[1] = 16'h0100;
    mem[16'h2000 >> 1] = 16'h0020;
    load_regs();
    ack_delay = 2;
    start = 1'b1; mode = 3'd7; rsel = 3'd1; byte_op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mem_req && mem_addr == 16'h0120) break;
      @(posedge clk); #1;
    end
    check("m7_reached_ptr", 128'(mem_req && mem_addr == 16'h0120), 128'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("mid_op_reset");
    reset_n = 1'b1;
    check("m7_pc_kept", 128'(rf[7]), 128'h2002);
    rf_next[5] = 16'hBEEF;
    load_regs();
    run_op(3'd0, 3'd5, 1'b0, 0, lat, reqc);
    check("post_reset_latency", 128'(lat), 128'd1);
    check("post_reset_operand", 128'(operand), 128'hBEEF);

    // randomized operands
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 8; i++) begin
        rf_next[i] = 16'($urandom);
        if ($urandom_range(0, 1) == 0) rf_next[i][0] = 1'b0;
      end
      rf_next[7][0] = 1'b0;
      load_regs();
      run_op(3'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 2), lat, reqc);
    end

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
